// File: rtl/imem_boot_loader_if.sv
// Byte-stream load channel into the instruction memory controller.
// Source drives valid/byte/last; the controller answers with ready.
interface imem_boot_loader_if;
   logic       ld_valid;
   logic       ld_ready;
   logic [7:0] ld_byte;
   logic       ld_last;

   modport master (
      output ld_valid,
      output ld_byte,
      output ld_last,
      input  ld_ready
   );

   modport slave (
      input  ld_valid,
      input  ld_byte,
      input  ld_last,
      output ld_ready
   );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction memory boot loader: streams an image into memory while
// stalling the core, then guards fetches against misaligned/stale reads.
module imem_boot_loader #(
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned ADDR_W   = 8,
   parameter logic [31:0] NOP_INSN = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reload,
   imem_boot_loader_if.slave ld,
   output logic              core_stall,
   input  logic [31:0]       fetch_addr,
   output logic [31:0]       fetch_instr,
   output logic              fetch_err,
   output logic [ADDR_W:0]   img_len,
   output logic              img_full,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [7:0]        mem_wdata,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] wptr;
   logic              beat;
   logic              at_end;

   assign beat   = ld.ld_valid & ld.ld_ready;
   assign at_end = (wptr == ADDR_W'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= LOAD;
         wptr        <= '0;
         img_len     <= '0;
         img_full    <= 1'b0;
         mem_we      <= 1'b0;
         mem_waddr   <= '0;
         mem_wdata   <= '0;
         core_stall  <= 1'b1;
         ld.ld_ready <= 1'b1;
      end else if (reload) begin
         // a beat seen together with reload is dropped
         state       <= LOAD;
         wptr        <= '0;
         img_len     <= '0;
         img_full    <= 1'b0;
         mem_we      <= 1'b0;
         core_stall  <= 1'b1;
         ld.ld_ready <= 1'b1;
      end else begin
         mem_we <= beat;
         if (beat) begin
            mem_waddr <= wptr;
            mem_wdata <= ld.ld_byte;
            wptr      <= wptr + ADDR_W'(1);
            img_len   <= img_len + (ADDR_W + 1)'(1);
            if (ld.ld_last | at_end) begin
               state       <= RUN;
               core_stall  <= 1'b0;
               ld.ld_ready <= 1'b0;
               if (!ld.ld_last)
                  img_full <= 1'b1;
            end
         end
      end
   end

   assign mem_raddr = {fetch_addr[ADDR_W-1:2], 2'b00};

   logic [32:0] end_addr;
   logic        bad;
   logic        in_run;

   // 33-bit compare keeps fetch_addr+3 from wrapping near 2^32
   always_comb begin
      end_addr    = {1'b0, fetch_addr} + 33'd3;
      in_run      = (state == RUN);
      bad         = (|fetch_addr[1:0])
                  | (end_addr >= 33'(img_len))
                  | ({1'b0, fetch_addr} >= 33'(DEPTH));
      fetch_err   = 1'b0;
      fetch_instr = NOP_INSN;
      unique case (1'b1)
         (!in_run):       fetch_instr = NOP_INSN;
         (in_run & bad):  fetch_err   = 1'b1;
         (in_run & !bad): fetch_instr = mem_rdata;
      endcase
   end

endmodule
